// File: rtl/seq_det_p.sv
// seq_det_p: serial pattern detector with loadable N-bit pattern, overlap select and saturating match count.
module seq_det_p #(
  parameter int N  = 3,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          i,
  input  logic [N-1:0]  a,
  input  logic          ld,
  input  logic          ovl,
  input  logic          clr,
  output logic          o,
  output logic [CW-1:0] y
);
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FULL = FW'(N);
  logic [N-1:0]  pat, sr, nxt;
  logic [FW-1:0] fill, fill_nxt;
  logic          match;
  assign nxt      = {sr[N-2:0], i};
  assign fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
  // fill gate keeps the zeroed shift register from matching before N real bits arrive
  assign match    = en && !ld && (fill_nxt == FULL) && (nxt == pat);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= '0;
      sr   <= '0;
      fill <= '0;
      o    <= 1'b0;
      y    <= '0;
    end else begin
      o <= match;
      if (clr) y <= '0;
      else if (match && y != '1) y <= y + 1'b1;
      if (ld) begin
        pat  <= a;
        sr   <= '0;
        fill <= '0;
      end else if (en) begin
        sr   <= nxt;
        fill <= match ? (ovl ? FULL : '0) : fill_nxt;
      end
    end
  end
endmodule
